// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the AHB-to-APB master controller.
// Holds the controller state encoding, AHB response codes and width helpers.
// No logic lives here; it is imported by every file of the bridge.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WWAIT  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Width of a field able to index n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/apb_rsp_mux.sv
// Selects the addressed slave's read data, ready and error out of the APB fabric.
// Purely combinational, zero latency.
// An index beyond the populated slaves returns all-zero (never ready, no error).
module apb_rsp_mux
  import apb_bridge_pkg::*;
#(
  parameter int NSLV   = 7,
  parameter int DATA_W = 32,
  localparam int SW    = idx_width(NSLV)
) (
  input  logic [SW-1:0]          idx_i,
  input  logic [NSLV*DATA_W-1:0] prdata_i,
  input  logic [NSLV-1:0]        pready_i,
  input  logic [NSLV-1:0]        pslverr_i,
  output logic [DATA_W-1:0]      prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o
);

  // Pick the slice belonging to the selected slave; everything else is ignored.
  always_comb begin
    prdata_o  = '0;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (int'(idx_i) == i) begin
        prdata_o  = prdata_i[i*DATA_W +: DATA_W];
        pready_o  = pready_i[i];
        pslverr_o = pslverr_i[i];
      end
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// AHB-side single-transfer to APB master: decode, SETUP/ACCESS with waits, timeout.
// Read 3 cycles, write 4 cycles at zero wait; each PREADY-low cycle adds one.
// hreadyout low while a transfer is in flight; errors return a two-cycle ERROR.
module apb_master_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 7,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                   pclk,
  input  logic                   hresetn,
  input  logic                   valid,
  input  logic                   hwrite,
  input  logic [ADDR_W-1:0]      haddr,
  input  logic [DATA_W-1:0]      hwdata,
  output logic                   hreadyout,
  output logic                   hresp,
  output logic [DATA_W-1:0]      hrdata,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV-1:0]        pslverr
);

  localparam int SW = idx_width(NSLV);
  localparam int CW = idx_width(TIMEOUT + 1);
  // Counter value seen on the last ACCESS cycle allowed before abort.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [SW-1:0]       idx_q, idx_d, idx_in;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NSLV-1:0]     psel_q, psel_d;
  logic                penable_q, penable_d;

  logic                accept;
  logic                idx_bad;
  logic                timed_out;
  logic [DATA_W-1:0]   sel_prdata;
  logic                sel_pready;
  logic                sel_pslverr;

  assign idx_in    = haddr[SEL_LSB +: SW];
  assign idx_bad   = (int'(idx_in) >= NSLV);
  assign accept    = valid && hreadyout;
  assign timed_out = (TIMEOUT != 0) && !sel_pready && (cnt_q == TO_LAST);

  apb_rsp_mux #(
    .NSLV   (NSLV),
    .DATA_W (DATA_W)
  ) u_rsp_mux (
    .idx_i     (idx_q),
    .prdata_i  (prdata),
    .pready_i  (pready),
    .pslverr_i (pslverr),
    .prdata_o  (sel_prdata),
    .pready_o  (sel_pready),
    .pslverr_o (sel_pslverr)
  );

  // State register; reset abandons any transfer without a response.
  always_ff @(posedge pclk or negedge hresetn) begin
    if (!hresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: ERR2 doubles as an accepting state so errors cost no idle cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERR2: begin
        if (accept) begin
          if (idx_bad)     state_d = ERR1;
          else if (hwrite) state_d = WWAIT;
          else             state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      WWAIT:  state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (sel_pready)     state_d = sel_pslverr ? ERR1 : IDLE;
        else if (timed_out) state_d = ERR1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // AHB handshake outputs decoded from the current state.
  always_comb begin
    hreadyout = (state_q == IDLE) || (state_q == ERR2);
    hresp     = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  // Datapath next values: address phase capture, write data, read return, wait count.
  always_comb begin
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;
    if (accept) begin
      idx_d    = idx_in;
      paddr_d  = haddr;
      pwrite_d = hwrite;
    end
    if (state_q == WWAIT) pwdata_d = hwdata;
    if ((state_q == ACCESS) && sel_pready && !sel_pslverr && !pwrite_q) hrdata_d = sel_prdata;
    // Held at zero outside ACCESS so every access starts counting from zero.
    if (state_q != ACCESS)                        cnt_d = '0;
    else if (!sel_pready && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // APB strobes come from the next state so they leave flops with no decode glitches.
  always_comb begin
    psel_d    = '0;
    penable_d = (state_d == ACCESS);
    if ((state_d == SETUP) || (state_d == ACCESS)) begin
      for (int i = 0; i < NSLV; i++) begin
        if (int'(idx_d) == i) psel_d[i] = 1'b1;
      end
    end
  end

  // Datapath and strobe registers.
  always_ff @(posedge pclk or negedge hresetn) begin
    if (!hresetn) begin
      idx_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      cnt_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      hrdata_q  <= hrdata_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign hrdata  = hrdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed table, randomized transfers vs a latency model,
// and a reset-during-ACCESS sequence followed by back-to-back reads.
module tb_apb_master_ctrl;

  localparam int NS = 7;
  localparam int TO = 4;

  logic              pclk = 1'b0;
  logic              hresetn;
  logic              valid, hwrite;
  logic [31:0]       haddr, hwdata;
  logic              hreadyout, hresp, penable, pwrite;
  logic [31:0]       hrdata, paddr, pwdata;
  logic [NS-1:0]     psel, pready, pslverr;
  logic [NS*32-1:0]  prdata;

  int checks   = 0;
  int failures = 0;

  // Reference state for the randomized section.
  logic [31:0] hrd_m, pwd_m, paddr_m;
  logic        pwrite_m;

  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .NSLV(NS), .SEL_LSB(12), .TIMEOUT(TO)) dut (
    .pclk(pclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite), .haddr(haddr),
    .hwdata(hwdata), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          waits;
    logic        serr;
    logic [31:0] rdat;
    int          exp_lat;
    logic        exp_err;
    logic [6:0]  exp_psel;
    int          exp_acc;
    logic [31:0] exp_hrdata;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hreadyout"}, 32'(hreadyout), 32'd1);
    chk({tag, "_hresp"},     32'(hresp),     32'd0);
    chk({tag, "_psel"},      32'(psel),      32'd0);
    chk({tag, "_penable"},   32'(penable),   32'd0);
    chk({tag, "_pwrite"},    32'(pwrite),    32'd0);
    chk({tag, "_paddr"},     paddr,          32'd0);
    chk({tag, "_pwdata"},    pwdata,         32'd0);
    chk({tag, "_hrdata"},    hrdata,         32'd0);
  endtask

  // Fill all slave response lanes with noise, the addressed lane returning rdat.
  task automatic noise_slaves(input int idx, input logic [31:0] rdat);
    pready  = NS'($urandom);
    pslverr = NS'($urandom);
    for (int s = 0; s < NS; s++) prdata[s*32 +: 32] = (s == idx) ? rdat : $urandom;
  endtask

  // Drives one transfer from a negedge where hreadyout is high; acts as the
  // addressed APB slave. Returns when hreadyout rises again (bounded).
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, input logic serr, input logic [31:0] rdat,
                          output int lat, output logic err_prev, output logic err_done,
                          output logic [6:0] psel_seen, output int n_setup, output int n_acc);
    int   idx;
    int   k;
    logic prev_hresp;
    idx = int'(addr[14:12]);
    valid = 1'b1; hwrite = wr; haddr = addr; hwdata = $urandom;
    noise_slaves(idx, rdat);
    lat = -1; err_prev = 1'b0; err_done = 1'b0; psel_seen = '0;
    n_setup = 0; n_acc = 0; k = 0; prev_hresp = hresp;
    for (int n = 1; n <= 60; n++) begin
      @(negedge pclk);
      valid  = 1'b0;
      hwdata = (n == 1 && wr) ? wd : $urandom;
      noise_slaves(idx, rdat);
      psel_seen |= psel;
      if (psel != 0 && !penable) n_setup++;
      if (psel != 0 && penable) begin
        n_acc++;
        if (idx < NS) begin
          pready[idx]  = (k == waits);
          pslverr[idx] = serr;
        end
        k++;
      end
      if (hreadyout) begin
        lat = n; err_done = hresp; err_prev = prev_hresp;
        break;
      end
      prev_hresp = hresp;
    end
    if (lat < 0) begin
      failures++; checks++;
      $display("FAIL xfer_timeout got=no_hreadyout exp=hreadyout_within_60");
    end
  endtask

  // Expected response from the transfer rules: decode error, slave error, timeout.
  task automatic model(input logic wr, input logic [31:0] addr, input int waits, input logic serr,
                       output int lat, output logic err, output logic [6:0] psel_exp,
                       output int acc, output int setup);
    int idx;
    idx = int'(addr[14:12]);
    if (idx >= NS) begin
      lat = 2; err = 1'b1; psel_exp = '0; acc = 0; setup = 0;
    end else begin
      acc      = (waits >= TO) ? TO : waits + 1;
      err      = (waits >= TO) || serr;
      lat      = (wr ? 1 : 0) + 2 + acc + (err ? 1 : 0);
      psel_exp = 7'(1 << idx);
      setup    = 1;
    end
  endtask

  task automatic model_commit(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                              input logic err, input logic [31:0] rdat);
    paddr_m  = addr;
    pwrite_m = wr;
    if (int'(addr[14:12]) < NS) begin
      if (wr) pwd_m = wd;
      else if (!err) hrd_m = rdat;
    end
  endtask

  initial begin
    int lat, n_setup, n_acc, e_lat, e_acc, e_setup;
    logic err_prev, err_done, e_err;
    logic [6:0] psel_seen, e_psel;

    tbl[0] = '{1'b0, 32'h0000_2010, 32'h0, 0,  1'b0, 32'hCAFE_0001, 3, 1'b0, 7'b0000100, 1, 32'hCAFE_0001};
    tbl[1] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 3, 1'b0, 32'h1111_1111, 7, 1'b0, 7'b0000001, 4, 32'hCAFE_0001};
    tbl[2] = '{1'b0, 32'h0000_5000, 32'h0, 1,  1'b1, 32'h5555_5555, 5, 1'b1, 7'b0100000, 2, 32'hCAFE_0001};
    tbl[3] = '{1'b0, 32'h0000_7000, 32'h0, 0,  1'b0, 32'h7777_7777, 2, 1'b1, 7'b0000000, 0, 32'hCAFE_0001};
    tbl[4] = '{1'b0, 32'h0000_3004, 32'h0, 10, 1'b0, 32'h3333_3333, 7, 1'b1, 7'b0001000, 4, 32'hCAFE_0001};
    tbl[5] = '{1'b1, 32'h0000_6008, 32'hDEAD_BEEF, 0, 1'b0, 32'h6666_6666, 4, 1'b0, 7'b1000000, 1, 32'hCAFE_0001};
    tbl[6] = '{1'b0, 32'h0000_6FFC, 32'h0, 2,  1'b0, 32'h0BAD_F00D, 5, 1'b0, 7'b1000000, 3, 32'h0BAD_F00D};

    hresetn = 1'b0; valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    pready = '0; pslverr = '0; prdata = '0;
    hrd_m = '0; pwd_m = '0; paddr_m = '0; pwrite_m = 1'b0;
    #2;
    chk_reset_vals("rst");
    repeat (2) @(negedge pclk);
    hresetn = 1'b1;

    // Directed table.
    foreach (tbl[i]) begin
      run_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].waits, tbl[i].serr, tbl[i].rdat,
               lat, err_prev, err_done, psel_seen, n_setup, n_acc);
      chk($sformatf("tbl%0d_lat", i),    32'(lat),       32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_err1", i),   32'(err_prev),  32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_err2", i),   32'(err_done),  32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_psel", i),   32'(psel_seen), 32'(tbl[i].exp_psel));
      chk($sformatf("tbl%0d_acc", i),    32'(n_acc),     32'(tbl[i].exp_acc));
      chk($sformatf("tbl%0d_hrdata", i), hrdata,         tbl[i].exp_hrdata);
      chk($sformatf("tbl%0d_paddr", i),  paddr,          tbl[i].addr);
      if (tbl[i].wr) chk($sformatf("tbl%0d_pwdata", i), pwdata, tbl[i].wd);
      model_commit(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].exp_err, tbl[i].rdat);
    end

    // Randomized transfers against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic        wr, serr;
      logic [31:0] addr, wd, rdat;
      int          waits, idx;
      wr    = 1'($urandom_range(0, 1));
      idx   = $urandom_range(0, 7);
      waits = $urandom_range(0, 5);
      serr  = ($urandom_range(0, 5) == 0);
      addr  = ($urandom & 32'hFFFF_8FFF) | (32'(idx) << 12);
      wd    = $urandom;
      rdat  = $urandom;
      if ($urandom_range(0, 3) == 0) @(negedge pclk);
      model(wr, addr, waits, serr, e_lat, e_err, e_psel, e_acc, e_setup);
      run_xfer(wr, addr, wd, waits, serr, rdat, lat, err_prev, err_done, psel_seen, n_setup, n_acc);
      model_commit(wr, addr, wd, e_err, rdat);
      chk($sformatf("rnd%0d_lat", t),    32'(lat),       32'(e_lat));
      chk($sformatf("rnd%0d_err", t),    32'(err_done),  32'(e_err));
      chk($sformatf("rnd%0d_psel", t),   32'(psel_seen), 32'(e_psel));
      chk($sformatf("rnd%0d_acc", t),    32'(n_acc),     32'(e_acc));
      chk($sformatf("rnd%0d_setup", t),  32'(n_setup),   32'(e_setup));
      chk($sformatf("rnd%0d_hrdata", t), hrdata,         hrd_m);
      chk($sformatf("rnd%0d_pwdata", t), pwdata,         pwd_m);
      chk($sformatf("rnd%0d_paddr", t),  paddr,          paddr_m);
      chk($sformatf("rnd%0d_pwrite", t), 32'(pwrite),    32'(pwrite_m));
    end

    // Reset during ACCESS with the slave stalled.
    begin
      bit seen_access;
      seen_access = 1'b0;
      @(negedge pclk);
      valid = 1'b1; hwrite = 1'b0; haddr = 32'h0000_4000; pready = '0; pslverr = '0;
      for (int n = 0; n < 10; n++) begin
        @(negedge pclk);
        valid = 1'b0;
        if (penable) begin
          seen_access = 1'b1;
          break;
        end
      end
      chk("midrst_reached_access", 32'(seen_access), 32'd1);
      hresetn = 1'b0;
      #1;
      chk_reset_vals("midrst");
      hrd_m = '0; pwd_m = '0; paddr_m = '0; pwrite_m = 1'b0;
      @(negedge pclk);
      hresetn = 1'b1;
    end

    // Two back-to-back reads: hreadyout pulses three cycles apart.
    run_xfer(1'b0, 32'h0000_1000, 32'h0, 0, 1'b0, 32'hA5A5_0001, lat, err_prev, err_done,
             psel_seen, n_setup, n_acc);
    chk("b2b0_lat",    32'(lat), 32'd3);
    chk("b2b0_hrdata", hrdata,   32'hA5A5_0001);
    run_xfer(1'b0, 32'h0000_2000, 32'h0, 0, 1'b0, 32'hA5A5_0002, lat, err_prev, err_done,
             psel_seen, n_setup, n_acc);
    chk("b2b1_lat",    32'(lat),       32'd3);
    chk("b2b1_hrdata", hrdata,         32'hA5A5_0002);
    chk("b2b1_psel",   32'(psel_seen), 32'b0000100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
